// File: rtl/cpu_sc.sv
// Single-cycle LEGv8 core: PC, decode, ALU, sign-extend, branch, write-back.
// Ports: CLOCK/RESET; INSTRUCTION, REG_DATA1/2, data_memory_out in;
//   READ_REG_1/2, WRITE_REG, ALU_Result_Out, WRITE_REG_DATA, PC and the
//   control lines REG2LOC/REGWRITE/MEMREAD/MEMWRITE/BRANCH out.
// Optional: define CPU_SC_CBNZ_EN to decode CBNZ (10110101).
module cpu_sc #(
  parameter logic [63:0] PC_RESET = 64'h0
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic [63:0] REG_DATA1,
  input  logic [63:0] REG_DATA2,
  input  logic [63:0] data_memory_out,
  output logic [4:0]  READ_REG_1,
  output logic [4:0]  READ_REG_2,
  output logic [4:0]  WRITE_REG,
  output logic [63:0] ALU_Result_Out,
  output logic [63:0] WRITE_REG_DATA,
  output logic [63:0] PC,
  output logic        REG2LOC,
  output logic        REGWRITE,
  output logic        MEMREAD,
  output logic        MEMWRITE,
  output logic        BRANCH
);

  logic [10:0] op11;
  logic        is_add, is_sub, is_and, is_orr;
  logic        is_ldur, is_stur, is_cbz, is_cbnz, is_b;
  logic [63:0] imm_d, off_cb, off_b;

  assign op11    = INSTRUCTION[31:21];
  assign is_add  = (op11 == 11'b10001011000);
  assign is_sub  = (op11 == 11'b11001011000);
  assign is_and  = (op11 == 11'b10001010000);
  assign is_orr  = (op11 == 11'b10101010000);
  assign is_ldur = (op11 == 11'b11111000010);
  assign is_stur = (op11 == 11'b11111000000);
  assign is_cbz  = (INSTRUCTION[31:24] == 8'b10110100);
  assign is_b    = (INSTRUCTION[31:26] == 6'b000101);
`ifdef CPU_SC_CBNZ_EN
  assign is_cbnz = (INSTRUCTION[31:24] == 8'b10110101);
`else
  assign is_cbnz = 1'b0;
`endif

  assign imm_d  = {{55{INSTRUCTION[20]}}, INSTRUCTION[20:12]};
  assign off_cb = {{45{INSTRUCTION[23]}}, INSTRUCTION[23:5]};
  assign off_b  = {{38{INSTRUCTION[25]}}, INSTRUCTION[25:0]};

  logic        reg2loc_c, regwrite_c, memread_c, memwrite_c;
  logic        branch_c, memtoreg_c, uncond_c, cbz_c, cbnz_c;
  logic [63:0] alu_c, off_c;

  always_comb begin
    reg2loc_c  = 1'b0;
    regwrite_c = 1'b0;
    memread_c  = 1'b0;
    memwrite_c = 1'b0;
    branch_c   = 1'b0;
    memtoreg_c = 1'b0;
    uncond_c   = 1'b0;
    cbz_c      = 1'b0;
    cbnz_c     = 1'b0;
    alu_c      = 64'h0;
    off_c      = 64'h0;
    unique case (1'b1)
      is_add: begin
        alu_c      = REG_DATA1 + REG_DATA2;
        regwrite_c = 1'b1;
      end
      is_sub: begin
        alu_c      = REG_DATA1 - REG_DATA2;
        regwrite_c = 1'b1;
      end
      is_and: begin
        alu_c      = REG_DATA1 & REG_DATA2;
        regwrite_c = 1'b1;
      end
      is_orr: begin
        alu_c      = REG_DATA1 | REG_DATA2;
        regwrite_c = 1'b1;
      end
      is_ldur: begin
        alu_c      = REG_DATA1 + imm_d;
        memread_c  = 1'b1;
        memtoreg_c = 1'b1;
        regwrite_c = 1'b1;
      end
      is_stur: begin
        alu_c      = REG_DATA1 + imm_d;
        reg2loc_c  = 1'b1;
        memwrite_c = 1'b1;
      end
      is_cbz: begin
        alu_c     = REG_DATA2;
        reg2loc_c = 1'b1;
        branch_c  = 1'b1;
        cbz_c     = 1'b1;
        off_c     = off_cb;
      end
      is_cbnz: begin
        alu_c     = REG_DATA2;
        reg2loc_c = 1'b1;
        branch_c  = 1'b1;
        cbnz_c    = 1'b1;
        off_c     = off_cb;
      end
      is_b: begin
        branch_c = 1'b1;
        uncond_c = 1'b1;
        off_c    = off_b;
      end
      default: ;
    endcase
  end

  logic        zero, taken;
  logic [63:0] pc_q, pc_d;

  assign zero  = (alu_c == 64'h0);
  assign taken = uncond_c | (cbz_c & zero) | (cbnz_c & ~zero);
  assign pc_d  = taken ? pc_q + (off_c << 2) : pc_q + 64'd4;

  always_ff @(posedge CLOCK) begin
    if (RESET) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  assign PC             = pc_q;
  assign READ_REG_1     = INSTRUCTION[9:5];
  assign READ_REG_2     = reg2loc_c ? INSTRUCTION[4:0]
                                    : INSTRUCTION[20:16];
  assign WRITE_REG      = INSTRUCTION[4:0];
  assign ALU_Result_Out = alu_c;
  assign WRITE_REG_DATA = memtoreg_c ? data_memory_out : alu_c;
  assign REG2LOC        = reg2loc_c;
  assign BRANCH         = branch_c;
  // No architectural writes while held in reset.
  assign REGWRITE       = regwrite_c & ~RESET;
  assign MEMREAD        = memread_c & ~RESET;
  assign MEMWRITE       = memwrite_c & ~RESET;

endmodule

// File: tb/tb_cpu_sc.sv
// Bench for cpu_sc: directed cases plus random instructions
// checked against an instruction-level reference model.
module tb_cpu_sc;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [63:0] REG_DATA1, REG_DATA2, data_memory_out;
  logic [4:0]  READ_REG_1, READ_REG_2, WRITE_REG;
  logic [63:0] ALU_Result_Out, WRITE_REG_DATA, PC;
  logic        REG2LOC, REGWRITE, MEMREAD, MEMWRITE, BRANCH;

  cpu_sc dut (
    .CLOCK(CLOCK), .RESET(RESET), .INSTRUCTION(INSTRUCTION),
    .REG_DATA1(REG_DATA1), .REG_DATA2(REG_DATA2),
    .data_memory_out(data_memory_out),
    .READ_REG_1(READ_REG_1), .READ_REG_2(READ_REG_2),
    .WRITE_REG(WRITE_REG), .ALU_Result_Out(ALU_Result_Out),
    .WRITE_REG_DATA(WRITE_REG_DATA), .PC(PC),
    .REG2LOC(REG2LOC), .REGWRITE(REGWRITE), .MEMREAD(MEMREAD),
    .MEMWRITE(MEMWRITE), .BRANCH(BRANCH)
  );

  always #5 CLOCK = ~CLOCK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [63:0] m_pc;

  // Expected architectural behaviour of one instruction.
  logic [4:0]  e_rr2;
  logic [63:0] e_alu, e_wd, e_npc;
  logic        e_r2l, e_rw, e_mr, e_mw, e_br;

  task automatic model(input logic [31:0] ins,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] dm, input logic rst);
    string mn;
    longint off;
    logic [10:0] o11;
    logic [7:0]  o8;
    logic [5:0]  o6;
    o11 = ins[31:21]; o8 = ins[31:24]; o6 = ins[31:26];
    mn = "NOP";
    if      (o11 == 11'h458) mn = "ADD";
    else if (o11 == 11'h658) mn = "SUB";
    else if (o11 == 11'h450) mn = "AND";
    else if (o11 == 11'h550) mn = "ORR";
    else if (o11 == 11'h7C2) mn = "LDUR";
    else if (o11 == 11'h7C0) mn = "STUR";
    else if (o8 == 8'hB4)    mn = "CBZ";
    else if (o6 == 6'h05)    mn = "B";
`ifdef CPU_SC_CBNZ_EN
    else if (o8 == 8'hB5)    mn = "CBNZ";
`endif
    e_alu = 0; e_r2l = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_br = 0;
    e_npc = m_pc + 4;
    case (mn)
      "ADD": begin e_alu = a + b; e_rw = 1; end
      "SUB": begin e_alu = a - b; e_rw = 1; end
      "AND": begin e_alu = a & b; e_rw = 1; end
      "ORR": begin e_alu = a | b; e_rw = 1; end
      "LDUR", "STUR": begin
        off = longint'($signed(ins[20:12]));
        e_alu = a + 64'(off);
        if (mn == "LDUR") begin e_mr = 1; e_rw = 1; end
        else begin e_r2l = 1; e_mw = 1; end
      end
      "CBZ", "CBNZ": begin
        e_alu = b; e_r2l = 1; e_br = 1;
        off = longint'($signed(ins[23:5]));
        if ((mn == "CBZ") == (b == 0))
          e_npc = m_pc + 64'(off * 4);
      end
      "B": begin
        e_br = 1;
        off = longint'($signed(ins[25:0]));
        e_npc = m_pc + 64'(off * 4);
      end
      default: ;
    endcase
    e_wd  = (mn == "LDUR") ? dm : e_alu;
    e_rr2 = e_r2l ? ins[4:0] : ins[20:16];
    if (rst) begin e_rw = 0; e_mr = 0; e_mw = 0; e_npc = 64'h0; end
  endtask

  // Apply one instruction, check outputs, clock it, check new PC.
  task automatic step(input logic [31:0] ins,
                      input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] dm, input logic rst);
    INSTRUCTION = ins; REG_DATA1 = a; REG_DATA2 = b;
    data_memory_out = dm; RESET = rst;
    model(ins, a, b, dm, rst);
    #1;
    check("pc", PC, m_pc);
    check("rr1", 64'(READ_REG_1), 64'(ins[9:5]));
    check("rr2", 64'(READ_REG_2), 64'(e_rr2));
    check("wr", 64'(WRITE_REG), 64'(ins[4:0]));
    check("alu", ALU_Result_Out, e_alu);
    check("wd", WRITE_REG_DATA, e_wd);
    check("ctl", 64'({REG2LOC, REGWRITE, MEMREAD, MEMWRITE, BRANCH}),
          64'({e_r2l, e_rw, e_mr, e_mw, e_br}));
    @(posedge CLOCK);
    #1;
    m_pc = e_npc;
    check("npc", PC, m_pc);
  endtask

  logic [31:0] rins;
  logic [63:0] ra, rb;

  initial begin
    INSTRUCTION = 0; REG_DATA1 = 0; REG_DATA2 = 0;
    data_memory_out = 0; RESET = 1;
    @(posedge CLOCK); #1;
    m_pc = 64'h0;
    check("rst_pc", PC, 64'h0);

    step(32'h8B020023, 5, 7, 0, 0);
    check("add_pc", PC, 64'h4);
    step(32'hF8408024, 64'h100, 0, 64'hDEAD, 0);
    step(32'hF8008024, 64'h100, 64'h55, 0, 0);
    step(32'h00000000, 1, 2, 3, 0);
    check("at_10", PC, 64'h10);
    step(32'hB4000065, 0, 1, 0, 0);
    check("cbz_nt", PC, 64'h14);
    step(32'h17FFFFFF, 0, 0, 0, 0);
    check("b_m1", PC, 64'h10);
    step(32'hB4000065, 0, 0, 0, 0);
    check("cbz_t", PC, 64'h1C);
    step(32'h00000000, 0, 0, 0, 0);
    step(32'h17FFFFFE, 0, 0, 0, 0);
    check("b_back", PC, 64'h18);
    step(32'h14000000, 0, 0, 0, 0);
    check("b_self", PC, 64'h18);
    step(32'hB5000065, 0, 1, 0, 0);
    for (int i = 0; i < 20 && PC != 64'h40; i++)
      step(32'h0, 0, 0, 0, 0);
    check("at_40", PC, 64'h40);
    step(32'hF8408024, 64'h100, 0, 64'hDEAD, 1);
    check("rst_mid", PC, 64'h0);

    for (int i = 0; i < 400; i++) begin
      rins = $urandom;
      case ($urandom_range(0, 9))
        0: rins[31:21] = 11'h458;
        1: rins[31:21] = 11'h658;
        2: rins[31:21] = 11'h450;
        3: rins[31:21] = 11'h550;
        4: rins[31:21] = 11'h7C2;
        5: rins[31:21] = 11'h7C0;
        6: rins[31:24] = 8'hB4;
        7: rins[31:24] = 8'hB5;
        8: rins[31:26] = 6'h05;
        default: ;
      endcase
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 2) == 0) ? 64'h0 : {$urandom, $urandom};
      step(rins, ra, rb, {$urandom, $urandom},
           ($urandom_range(0, 39) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
